peak_to_dds_ctrl: RTL and testbench

Downstream of the FFT peak classifier. Each FFT frame, it samples the peak bins (max1_idx, max2_idx) and wave_type. It qualifies them over several consecutive frames, then converts each bin index into a 32-bit DDS frequency tuning word (FTW) with a per-channel triangle/sine select. Outputs feed the two regeneration DDS channels: A = lower bin, B = higher bin.

---
 rtl/peak_to_dds_ctrl_pkg.sv | 28 ++
 rtl/peak_to_dds_ctrl_seq_mul_10x32.sv | 66 ++++++
 rtl/peak_to_dds_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_peak_to_dds_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_to_dds_ctrl_pkg.sv
// Shared types and constants for the FFT-peak to DDS tuning-word controller.
package peak_to_dds_ctrl_pkg;

  localparam int FTW_W  = 32;
  localparam int IDX_W  = 10;
  localparam int PROD_W = FTW_W + IDX_W;

  localparam logic [2:0] WT_NONE = 3'b000;
  localparam logic [2:0] WT_SS   = 3'b100;
  localparam logic [2:0] WT_TS   = 3'b110;
  localparam logic [2:0] WT_ST   = 3'b101;
  localparam logic [2:0] WT_TT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_MUL_A,
    S_MUL_B,
    S_PUBLISH
  } state_e;

  function automatic logic [IDX_W-1:0] idx_absdiff(input logic [IDX_W-1:0] a,
                                                   input logic [IDX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/peak_to_dds_ctrl_seq_mul_10x32.sv
// Sequential 10x32 unsigned shift-add multiplier, one multiplier bit per cycle.
module seq_mul_10x32
  import peak_to_dds_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  a_i,
  input  logic [FTW_W-1:0]  b_i,
  output logic              done_o,
  output logic [PROD_W-1:0] prod_o
);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [IDX_W-1:0]  mplier_q, mplier_d;
  logic [3:0]        step_q, step_d;
  logic              run_q, run_d;

  // The start cycle already accumulates bit 0, so ten edges cover all ten bits.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    step_d   = step_q;
    run_d    = run_q;
    if (start_i) begin
      acc_d    = a_i[0] ? PROD_W'(b_i) : '0;
      mcand_d  = PROD_W'(b_i) << 1;
      mplier_d = a_i >> 1;
      step_d   = 4'd1;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 4'd1;
      if (step_q == 4'(IDX_W - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      step_q   <= step_d;
      run_q    <= run_d;
    end
  end

  // done flags the cycle whose closing edge writes the final partial product.
  assign done_o = run_q && !start_i && (step_q == 4'(IDX_W - 1));
  assign prod_o = acc_q;

endmodule

// File: rtl/peak_to_dds_ctrl.sv
// Qualifies FFT peak bins over consecutive frames and publishes DDS tuning words.
module peak_to_dds_ctrl
  import peak_to_dds_ctrl_pkg::*;
#(
  parameter logic [31:0] FTW_K         = 32'd42950,
  parameter int          SETTLE_CYC    = 16,
  parameter int          STABLE_FRAMES = 3,
  parameter int          IDX_TOL       = 1,
  parameter int          IDX_MIN       = 2,
  parameter int          IDX_MAX       = 510
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_done,
  input  logic [2:0]  wave_type,
  input  logic [9:0]  max1_idx,
  input  logic [9:0]  max2_idx,
  output logic [31:0] ftw_a,
  output logic [31:0] ftw_b,
  output logic        tri_a,
  output logic        tri_b,
  output logic        ftw_valid,
  output logic        locked,
  output logic        busy
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNT_W = 4;

  state_e             state_q;
  logic [SET_W-1:0]   settle_q;
  logic               fd_q;
  logic               start_q;

  logic [2:0]         smp_wt_q;
  logic [IDX_W-1:0]   smp_i1_q, smp_i2_q;
  logic [2:0]         cand_wt_q, cand_wt_d;
  logic [IDX_W-1:0]   cand_i1_q, cand_i1_d, cand_i2_q, cand_i2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pub_wt_q;
  logic [IDX_W-1:0]   pub_i1_q, pub_i2_q;

  logic [FTW_W-1:0]   prod_a_q;
  logic [FTW_W-1:0]   ftw_a_q, ftw_b_q;
  logic               tri_a_q, tri_b_q, valid_q, locked_q, busy_q;

  logic               rise;
  logic               smp_bad, smp_match, go_mul;
  logic               mul_done;
  logic [PROD_W-1:0]  mul_prod;
  logic [IDX_W-1:0]   mul_a;

  function automatic logic [FTW_W-1:0] sat_ftw(input logic [PROD_W-1:0] p);
    return (|p[PROD_W-1:FTW_W]) ? {FTW_W{1'b1}} : p[FTW_W-1:0];
  endfunction

  assign rise  = frame_done & ~fd_q;
  assign mul_a = (state_q == S_MUL_B) ? cand_i2_q : cand_i1_q;

  seq_mul_10x32 u_mul (
    .clk     (clk),
    .rst_ni  (rst),
    .start_i (start_q),
    .a_i     (mul_a),
    .b_i     (FTW_K),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Frame qualification: the candidate holds its first values while matches accumulate.
  always_comb begin
    smp_bad = (smp_wt_q == WT_NONE)
           || (smp_i1_q < IDX_W'(IDX_MIN)) || (smp_i1_q > IDX_W'(IDX_MAX))
           || (smp_i2_q < IDX_W'(IDX_MIN)) || (smp_i2_q > IDX_W'(IDX_MAX))
           || (smp_i1_q > smp_i2_q);
    smp_match = (smp_wt_q == cand_wt_q)
             && (idx_absdiff(smp_i1_q, cand_i1_q) <= IDX_W'(IDX_TOL))
             && (idx_absdiff(smp_i2_q, cand_i2_q) <= IDX_W'(IDX_TOL));
    cand_wt_d = cand_wt_q;
    cand_i1_d = cand_i1_q;
    cand_i2_d = cand_i2_q;
    cnt_d     = cnt_q;
    if (smp_bad) begin
      cand_wt_d = WT_NONE;
      cand_i1_d = '0;
      cand_i2_d = '0;
      cnt_d     = '0;
    end else if (smp_match) begin
      cnt_d = (cnt_q >= CNT_W'(STABLE_FRAMES)) ? CNT_W'(STABLE_FRAMES) : cnt_q + 1'b1;
    end else begin
      cand_wt_d = smp_wt_q;
      cand_i1_d = smp_i1_q;
      cand_i2_d = smp_i2_q;
      cnt_d     = CNT_W'(1);
    end
    go_mul = !smp_bad && (cnt_d == CNT_W'(STABLE_FRAMES))
          && (!locked_q || (cand_wt_d != pub_wt_q)
              || (cand_i1_d != pub_i1_q) || (cand_i2_d != pub_i2_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      fd_q      <= 1'b0;
      start_q   <= 1'b0;
      smp_wt_q  <= '0;
      smp_i1_q  <= '0;
      smp_i2_q  <= '0;
      cand_wt_q <= '0;
      cand_i1_q <= '0;
      cand_i2_q <= '0;
      cnt_q     <= '0;
      pub_wt_q  <= '0;
      pub_i1_q  <= '0;
      pub_i2_q  <= '0;
      prod_a_q  <= '0;
      ftw_a_q   <= '0;
      ftw_b_q   <= '0;
      tri_a_q   <= 1'b0;
      tri_b_q   <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      fd_q    <= frame_done;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q  <= S_SETTLE;
            settle_q <= SET_W'(SETTLE_CYC - 1);
            busy_q   <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            smp_wt_q <= wave_type;
            smp_i1_q <= max1_idx;
            smp_i2_q <= max2_idx;
            state_q  <= S_CHECK;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_CHECK: begin
          cand_wt_q <= cand_wt_d;
          cand_i1_q <= cand_i1_d;
          cand_i2_q <= cand_i2_d;
          cnt_q     <= cnt_d;
          if (go_mul) begin
            state_q <= S_MUL_A;
            start_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_MUL_A: begin
          if (mul_done) begin
            state_q <= S_MUL_B;
            start_q <= 1'b1;
          end
        end
        S_MUL_B: begin
          // Product A is still in the accumulator on the edge that launches B.
          if (start_q) begin
            prod_a_q <= sat_ftw(mul_prod);
          end
          if (mul_done) begin
            state_q <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          ftw_a_q  <= prod_a_q;
          ftw_b_q  <= sat_ftw(mul_prod);
          tri_a_q  <= cand_wt_q[1];
          tri_b_q  <= cand_wt_q[0];
          pub_wt_q <= cand_wt_q;
          pub_i1_q <= cand_i1_q;
          pub_i2_q <= cand_i2_q;
          valid_q  <= 1'b1;
          locked_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ftw_a     = ftw_a_q;
  assign ftw_b     = ftw_b_q;
  assign tri_a     = tri_a_q;
  assign tri_b     = tri_b_q;
  assign ftw_valid = valid_q;
  assign locked    = locked_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_peak_to_dds_ctrl.sv
// Self-checking bench for peak_to_dds_ctrl: frame-level model plus directed literal checks.
module tb_peak_to_dds_ctrl;

  localparam logic [31:0] K  = 32'd42950;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_done = 1'b0;
  logic        frame_done2 = 1'b0;
  logic [2:0]  wave_type = 3'b000;
  logic [9:0]  max1_idx = 10'd0;
  logic [9:0]  max2_idx = 10'd0;

  logic [31:0] ftw_a, ftw_b, ftw_a2, ftw_b2;
  logic        tri_a, tri_b, ftw_valid, locked, busy;
  logic        tri_a2, tri_b2, ftw_valid2, locked2, busy2;

  always #5 clk = ~clk;

  peak_to_dds_ctrl dut (
    .clk(clk), .rst(rst), .frame_done(frame_done), .wave_type(wave_type),
    .max1_idx(max1_idx), .max2_idx(max2_idx), .ftw_a(ftw_a), .ftw_b(ftw_b),
    .tri_a(tri_a), .tri_b(tri_b), .ftw_valid(ftw_valid), .locked(locked), .busy(busy)
  );

  peak_to_dds_ctrl #(.FTW_K(32'h0100_0000)) dut2 (
    .clk(clk), .rst(rst), .frame_done(frame_done2), .wave_type(wave_type),
    .max1_idx(max1_idx), .max2_idx(max2_idx), .ftw_a(ftw_a2), .ftw_b(ftw_b2),
    .tri_a(tri_a2), .tri_b(tri_b2), .ftw_valid(ftw_valid2), .locked(locked2), .busy(busy2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Frame-level reference model
  logic [2:0]  m_cwt, m_pwt;
  int          m_c1, m_c2, m_cnt, m_p1, m_p2;
  bit          m_locked;
  int          m_bs, m_be;
  bit          pend;
  int          pend_cyc;
  logic [31:0] pend_a, pend_b;
  logic        pend_ta, pend_tb;
  logic [31:0] e_a, e_b;
  logic        e_ta, e_tb, e_locked;

  function automatic logic [31:0] ftw_of(input int idx, input logic [31:0] k);
    longint p;
    p = longint'(idx) * longint'({32'd0, k});
    return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_cwt = 3'b000; m_pwt = 3'b000;
    m_c1 = 0; m_c2 = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0;
    m_locked = 1'b0; m_bs = -1; m_be = -1; pend = 1'b0; pend_cyc = -1;
    pend_a = '0; pend_b = '0; pend_ta = 1'b0; pend_tb = 1'b0;
    e_a = '0; e_b = '0; e_ta = 1'b0; e_tb = 1'b0; e_locked = 1'b0;
  endtask

  task automatic model_frame(input int e, input logic [2:0] wt, input int a, input int b);
    bit inv, match;
    m_bs = e;
    inv = (wt == 3'b000) || (a < 2) || (a > 510) || (b < 2) || (b > 510) || (a > b);
    if (inv) begin
      m_cwt = 3'b000; m_c1 = 0; m_c2 = 0; m_cnt = 0;
      m_be = e + 16;
      return;
    end
    match = (wt == m_cwt) && (absd(a, m_c1) <= 1) && (absd(b, m_c2) <= 1);
    if (match) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
    else begin
      m_cwt = wt; m_c1 = a; m_c2 = b; m_cnt = 1;
    end
    if (m_cnt == 3 && (!m_locked || m_cwt != m_pwt || m_c1 != m_p1 || m_c2 != m_p2)) begin
      m_locked = 1'b1; m_pwt = m_cwt; m_p1 = m_c1; m_p2 = m_c2;
      pend = 1'b1; pend_cyc = e + 38;
      pend_a = ftw_of(m_c1, K); pend_b = ftw_of(m_c2, K);
      pend_ta = m_cwt[1]; pend_tb = m_cwt[0];
      m_be = e + 37;
    end else begin
      m_be = e + 16;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic ev;
    ev = 1'b0;
    if (chk_en) begin
      if (pend && cyc == pend_cyc) begin
        ev = 1'b1; e_a = pend_a; e_b = pend_b; e_ta = pend_ta; e_tb = pend_tb;
        e_locked = 1'b1; pend = 1'b0;
      end
      chk("ftw_valid", ftw_valid, ev);
      chk("ftw_a", ftw_a, e_a);
      chk("ftw_b", ftw_b, e_b);
      chk("tri_a", tri_a, e_ta);
      chk("tri_b", tri_b, e_tb);
      chk("locked", locked, e_locked);
      chk("busy", busy, (cyc >= m_bs && cyc <= m_be));
    end
  end

  int pulses = 0, last_pulse = -1, pulses2 = 0;
  always @(negedge clk) begin
    if (ftw_valid === 1'b1) begin pulses++; last_pulse = cyc; end
    if (ftw_valid2 === 1'b1) pulses2++;
  end

  // mode 0: plain frame; 1: extra frame_done rise during SETTLE; 2: reset pulse during MUL_B
  task automatic frame(input logic [2:0] wt, input int a, input int b, input int mode, output int e);
    @(negedge clk);
    wave_type = wt; max1_idx = a[9:0]; max2_idx = b[9:0]; frame_done = 1'b1;
    e = cyc + 1;
    model_frame(e, wt, a, b);
    repeat (3) @(negedge clk);
    frame_done = 1'b0;
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      frame_done = 1'b1;
      repeat (2) @(negedge clk);
      frame_done = 1'b0;
    end
    if (mode == 2) begin
      while (cyc < e + 30) begin
        @(posedge clk);
        #1;
      end
      #1 rst = 1'b0;
      model_reset();
      @(posedge clk);
      #2 rst = 1'b1;
    end
    repeat (45) @(negedge clk);
  endtask

  task automatic frame2(input logic [2:0] wt, input int a, input int b);
    @(negedge clk);
    wave_type = wt; max1_idx = a[9:0]; max2_idx = b[9:0]; frame_done2 = 1'b1;
    repeat (3) @(negedge clk);
    frame_done2 = 1'b0;
    repeat (45) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e, p0;
    model_reset();
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ftw_a", ftw_a, 32'd0);
    chk("reset_locked", locked, 32'd0);
    chk("reset_valid", ftw_valid, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Three identical frames publish once, a fourth does not
    frame(3'b110, 20, 50, 0, e);
    frame(3'b110, 20, 50, 0, e);
    frame(3'b110, 20, 50, 0, e);
    chk("t1_pulse_cycle", last_pulse, e + 38);
    chk("t1_ftw_a", ftw_a, 32'd859000);
    chk("t1_ftw_b", ftw_b, 32'd2147500);
    chk("t1_tri_a", tri_a, 32'd1);
    chk("t1_tri_b", tri_b, 32'd0);
    chk("t1_locked", locked, 32'd1);
    p0 = pulses;
    frame(3'b110, 20, 50, 0, e);
    chk("t1_no_repeat", pulses, p0);
    chk("t1_pulse_total", pulses, 32'd1);

    // Jitter within tolerance keeps the first candidate
    frame(3'b000, 20, 50, 0, e);
    frame(3'b101, 20, 50, 0, e);
    frame(3'b101, 21, 49, 0, e);
    frame(3'b101, 19, 50, 0, e);
    chk("t2_pulses", pulses, p0 + 1);
    chk("t2_pulse_cycle", last_pulse, e + 38);
    chk("t2_ftw_a", ftw_a, 32'd859000);
    chk("t2_ftw_b", ftw_b, 32'd2147500);
    chk("t2_tri_a", tri_a, 32'd0);
    chk("t2_tri_b", tri_b, 32'd1);
    frame(3'b101, 20, 50, 0, e);
    frame(3'b101, 22, 50, 0, e);
    frame(3'b101, 22, 50, 0, e);
    chk("t2_restart_no_pub", pulses, p0 + 1);
    frame(3'b101, 22, 50, 0, e);
    chk("t2_restart_pub", pulses, p0 + 2);
    chk("t2_ftw_a_22", ftw_a, 32'd944900);

    // Invalid frame leaves outputs alone
    frame(3'b000, 22, 50, 0, e);
    chk("t3_hold_ftw_a", ftw_a, 32'd944900);
    chk("t3_hold_locked", locked, 32'd1);
    frame(3'b111, 30, 60, 0, e);
    frame(3'b111, 30, 60, 0, e);
    frame(3'b111, 30, 60, 0, e);
    chk("t3_ftw_a", ftw_a, 32'd1288500);
    chk("t3_ftw_b", ftw_b, 32'd2577000);
    chk("t3_tri_a", tri_a, 32'd1);
    chk("t3_tri_b", tri_b, 32'd1);

    // Reset during MUL_B aborts the publish
    p0 = pulses;
    frame(3'b100, 40, 80, 0, e);
    frame(3'b100, 40, 80, 0, e);
    frame(3'b100, 40, 80, 2, e);
    chk("t4_no_pulse", pulses, p0);
    chk("t4_ftw_a", ftw_a, 32'd0);
    chk("t4_ftw_b", ftw_b, 32'd0);
    chk("t4_locked", locked, 32'd0);
    frame(3'b100, 40, 80, 0, e);
    frame(3'b100, 40, 80, 0, e);
    chk("t4_two_frames_no_pub", pulses, p0);
    frame(3'b100, 40, 80, 0, e);
    chk("t4_pub", pulses, p0 + 1);
    chk("t4_ftw_a_pub", ftw_a, 32'd1718000);
    chk("t4_ftw_b_pub", ftw_b, 32'd3436000);

    // Extra rise in SETTLE is dropped; out-of-range frame clears the candidate
    p0 = pulses;
    frame(3'b111, 40, 80, 0, e);
    frame(3'b111, 40, 80, 1, e);
    frame(3'b111, 1, 511, 0, e);
    frame(3'b111, 40, 80, 0, e);
    chk("t5_cleared_no_pub", pulses, p0);
    chk("t5_hold_ftw_a", ftw_a, 32'd1718000);
    frame(3'b111, 40, 80, 0, e);
    frame(3'b111, 40, 80, 0, e);
    chk("t5_pub", pulses, p0 + 1);
    chk("t5_tri_a", tri_a, 32'd1);

    // Saturating tuning word on a large-K instance
    frame2(3'b110, 200, 300);
    frame2(3'b110, 200, 300);
    frame2(3'b110, 200, 300);
    chk("t6_ftw_a", ftw_a2, 32'hC800_0000);
    chk("t6_ftw_b_sat", ftw_b2, 32'hFFFF_FFFF);
    chk("t6_pulses", pulses2, 32'd1);
    chk("t6_locked", locked2, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
